// File: rtl/mpu_pkg.sv
// Shared types and constants for the memory protection controller.
// Region records, permission bit positions, fault codes and FSM encoding.
package mpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int PERM_R = 0;
  localparam int PERM_W = 1;
  localparam int PERM_X = 2;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_READ  = 2'd1;
  localparam logic [1:0] FAULT_WRITE = 2'd2;
  localparam logic [1:0] FAULT_EXEC  = 2'd3;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] limit;
    logic [2:0]  perm;
  } region_t;

  // Fetch outranks write, write outranks read.
  function automatic logic [2:0] req_perm_mask(input logic instr, input logic [3:0] wstrb);
    logic [2:0] mask;
    mask = '0;
    if (instr)       mask[PERM_X] = 1'b1;
    else if (|wstrb) mask[PERM_W] = 1'b1;
    else             mask[PERM_R] = 1'b1;
    return mask;
  endfunction

  function automatic logic [1:0] fault_code(input logic instr, input logic [3:0] wstrb);
    if (instr)       return FAULT_EXEC;
    else if (|wstrb) return FAULT_WRITE;
    else             return FAULT_READ;
  endfunction

endpackage

// File: rtl/mpu_region_match.sv
// Combinational region comparator array.
// Reports whether any enabled region covers the address and the perms of the lowest-index hit.
module mpu_region_match
  import mpu_pkg::*;
#(
  parameter int NREGION = 4
) (
  input  region_t     regions_i [NREGION],
  input  logic [31:0] addr_i,
  output logic        hit_o,
  output logic [2:0]  perm_o
);

  always_comb begin
    hit_o  = 1'b0;
    perm_o = '0;
    // Walk downwards so the lowest matching index is the last writer.
    for (int i = NREGION - 1; i >= 0; i--) begin
      if ((regions_i[i].perm != 3'b000) &&
          (regions_i[i].base <= addr_i) &&
          (addr_i <= regions_i[i].limit)) begin
        hit_o  = 1'b1;
        perm_o = regions_i[i].perm;
      end
    end
  end

endmodule

// File: rtl/mem_mpu_ctrl.sv
// Protection front-end between the picorv32 native bus and the word-array memory.
// state  | meaning
// IDLE   | waiting for mem_valid; request latched on acceptance
// CHECK  | range + region permission evaluation of the latched request
// ACCESS | single-cycle drive of the memory pins (m_wen live only here)
// DONE   | mem_ready pulse; fault_valid pulse when the access was denied
module mem_mpu_ctrl
  import mpu_pkg::*;
#(
  parameter  int NREGION   = 4,
  parameter  int MEM_WORDS = 1024,
  localparam int IDXW      = (NREGION > 1) ? $clog2(NREGION) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_instr,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic [3:0]      mem_wstrb,
  output logic            mem_ready,
  output logic [31:0]     mem_rdata,
  input  logic            mpu_en,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [31:0]     cfg_base,
  input  logic [31:0]     cfg_limit,
  input  logic [2:0]      cfg_perm,
  input  logic            cfg_lock,
  output logic            m_is_inst,
  output logic [3:0]      m_wen,
  output logic [21:0]     m_addr,
  output logic [31:0]     m_wdata,
  input  logic [31:0]     m_rdata,
  output logic            fault_valid,
  output logic [31:0]     fault_addr,
  output logic [1:0]      fault_type,
  output logic [15:0]     fault_count
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  region_t     regions_q [NREGION];
  logic        lock_q;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;

  logic        m_is_inst_q;
  logic [3:0]  m_wen_q;
  logic [21:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic        ready_q;
  logic        rd_ok_q;
  logic        fault_valid_q;
  logic [31:0] fault_addr_q;
  logic [1:0]  fault_type_q;
  logic [15:0] fault_count_q;
  logic [15:0] fault_count_d;

  logic        hit;
  logic [2:0]  hit_perm;
  logic        in_range;
  logic        allow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGION; i++) regions_q[i] <= '0;
      lock_q <= 1'b0;
    end else begin
      // Write and lock in the same cycle: the write still lands.
      if (cfg_we && !lock_q) begin
        for (int i = 0; i < NREGION; i++) begin
          if (cfg_idx == IDXW'(i)) begin
            regions_q[i] <= '{base: cfg_base, limit: cfg_limit, perm: cfg_perm};
          end
        end
      end
      if (cfg_lock) lock_q <= 1'b1;
    end
  end

  mpu_region_match #(
    .NREGION (NREGION)
  ) u_match (
    .regions_i (regions_q),
    .addr_i    (addr_q),
    .hit_o     (hit),
    .perm_o    (hit_perm)
  );

  assign in_range      = {2'b00, addr_q[31:2]} < MEM_WORDS_W;
  assign allow         = in_range &&
                         (!mpu_en || (hit && |(req_perm_mask(instr_q, wstrb_q) & hit_perm)));
  assign fault_count_d = (fault_count_q == 16'hFFFF) ? fault_count_q : fault_count_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      instr_q       <= 1'b0;
      m_is_inst_q   <= 1'b0;
      m_wen_q       <= '0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      ready_q       <= 1'b0;
      rd_ok_q       <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_type_q  <= FAULT_NONE;
      fault_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q       <= 1'b0;
          rd_ok_q       <= 1'b0;
          fault_valid_q <= 1'b0;
          if (mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (allow) begin
            m_addr_q    <= addr_q[23:2];
            m_wdata_q   <= wdata_q;
            m_is_inst_q <= instr_q;
            m_wen_q     <= wstrb_q;
            state_q     <= ST_ACCESS;
          end else begin
            ready_q       <= 1'b1;
            fault_valid_q <= 1'b1;
            fault_addr_q  <= addr_q;
            fault_type_q  <= fault_code(instr_q, wstrb_q);
            fault_count_q <= fault_count_d;
            state_q       <= ST_DONE;
          end
        end
        ST_ACCESS: begin
          m_wen_q     <= '0;
          m_is_inst_q <= 1'b0;
          ready_q     <= 1'b1;
          rd_ok_q     <= (wstrb_q == 4'b0000);
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          // mem_valid is deliberately not sampled here.
          ready_q       <= 1'b0;
          rd_ok_q       <= 1'b0;
          fault_valid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory read data is registered inside the memory, so it is valid during DONE.
  assign mem_rdata   = rd_ok_q ? m_rdata : '0;
  assign mem_ready   = ready_q;
  assign m_is_inst   = m_is_inst_q;
  assign m_wen       = m_wen_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
  assign fault_type  = fault_type_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_mem_mpu_ctrl.sv
// Scoreboard bench for mem_mpu_ctrl with a behavioural word-array memory.
// Each scenario task drives requests, queues the expected completion and checks it on mem_ready.
module tb_mem_mpu_ctrl;

  localparam int NREGION   = 4;
  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mpu_en = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_limit = '0;
  logic [2:0]  cfg_perm = '0;
  logic        cfg_lock = 1'b0;
  logic        m_is_inst;
  logic [3:0]  m_wen;
  logic [21:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [1:0]  fault_type;
  logic [15:0] fault_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_count = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  ftype;
    logic [3:0]  wen;
    logic [21:0] maddr;
    logic        inst;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] mem [MEM_WORDS] = '{default: 32'h0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (m_wen[b]) mem[m_addr[9:0]][b*8 +: 8] <= m_wdata[b*8 +: 8];
    end
    m_rdata <= mem[m_addr[9:0]];
  end

  mem_mpu_ctrl #(
    .NREGION   (NREGION),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mpu_en      (mpu_en),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_base    (cfg_base),
    .cfg_limit   (cfg_limit),
    .cfg_perm    (cfg_perm),
    .cfg_lock    (cfg_lock),
    .m_is_inst   (m_is_inst),
    .m_wen       (m_wen),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_type  (fault_type),
    .fault_count (fault_count)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] base, input logic [31:0] limit,
                           input logic [2:0] perm, input logic lock);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_idx   = idx;
    cfg_base  = base;
    cfg_limit = limit;
    cfg_perm  = perm;
    cfg_lock  = lock;
    @(negedge clk);
    cfg_we   = 1'b0;
    cfg_lock = 1'b0;
  endtask

  task automatic do_access(input string name, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic ins,
                           input logic exp_fault, input logic [31:0] exp_rd);
    exp_t e;
    exp_t got;
    int lat;
    logic [3:0]  wen_seen;
    logic [21:0] maddr_seen;
    logic        inst_seen;
    e.rdata = exp_fault ? 32'h0 : exp_rd;
    e.fault = exp_fault;
    e.ftype = ins ? 2'd3 : ((ws != 4'b0) ? 2'd2 : 2'd1);
    e.wen   = exp_fault ? 4'b0 : ws;
    e.maddr = a[23:2];
    e.inst  = !exp_fault && ins;
    e.lat   = exp_fault ? 2 : 3;
    if (exp_fault && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    sb_q.push_back(e);

    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_instr = ins;
    @(negedge clk);
    mem_valid = 1'b0;
    lat        = 1;
    wen_seen   = '0;
    maddr_seen = '0;
    inst_seen  = 1'b0;
    while (mem_ready !== 1'b1 && lat < 20) begin
      if (m_wen !== 4'b0) begin
        wen_seen   = m_wen;
        maddr_seen = m_addr;
      end
      if (m_is_inst === 1'b1) inst_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    got = sb_q.pop_front();
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: mem_ready never rose within %0d cycles", name, lat);
      return;
    end
    checks++;
    if (lat !== got.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, got.lat);
    end
    checks++;
    if (mem_rdata !== got.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", name, mem_rdata, got.rdata);
    end
    checks++;
    if (fault_valid !== got.fault) begin
      errors++;
      $display("FAIL %s fault_valid: got %b want %b", name, fault_valid, got.fault);
    end
    checks++;
    if (wen_seen !== got.wen) begin
      errors++;
      $display("FAIL %s m_wen: got %b want %b", name, wen_seen, got.wen);
    end
    if (got.wen != 4'b0) begin
      checks++;
      if (maddr_seen !== got.maddr) begin
        errors++;
        $display("FAIL %s m_addr: got %h want %h", name, maddr_seen, got.maddr);
      end
    end
    checks++;
    if (inst_seen !== got.inst) begin
      errors++;
      $display("FAIL %s m_is_inst: got %b want %b", name, inst_seen, got.inst);
    end
    checks++;
    if (fault_count !== exp_count) begin
      errors++;
      $display("FAIL %s fault_count: got %h want %h", name, fault_count, exp_count);
    end
    if (got.fault) begin
      checks++;
      if (fault_type !== got.ftype) begin
        errors++;
        $display("FAIL %s fault_type: got %0d want %0d", name, fault_type, got.ftype);
      end
      checks++;
      if (fault_addr !== a) begin
        errors++;
        $display("FAIL %s fault_addr: got %h want %h", name, fault_addr, a);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({mem_ready, fault_valid, m_wen, m_is_inst} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {mem_ready, fault_valid, m_wen, m_is_inst});
    end
    checks++;
    if ({m_addr, m_wdata, mem_rdata} !== 86'b0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {m_addr, m_wdata, mem_rdata});
    end
    checks++;
    if ({fault_addr, fault_type, fault_count} !== 50'b0) begin
      errors++;
      $display("FAIL reset_fault: got %h want 0", {fault_addr, fault_type, fault_count});
    end
    do_access("reset_no_regions", 32'h10, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_basic();
    do_reset();
    mpu_en = 1'b1;
    cfg_write(2'd0, 32'h0, 32'hFFF, 3'b011, 1'b0);
    do_access("basic_write", 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 32'h0);
    do_access("basic_read", 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hDEADBEEF);
    do_access("partial_write", 32'h14, 32'h11223344, 4'b0011, 1'b0, 1'b0, 32'h0);
    do_access("partial_read", 32'h14, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h00003344);
  endtask

  task automatic test_exec_fault();
    do_access("fetch_no_x", 32'h20, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
    do_access("exec_priority", 32'h24, 32'h12345678, 4'b1111, 1'b1, 1'b1, 32'h0);
    do_access("read_after_exec", 32'h24, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_range();
    mpu_en = 1'b0;
    do_access("range_over", 32'h1000, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
    do_access("range_last_wr", 32'hFFC, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b0, 32'h0);
    do_access("range_last_rd", 32'hFFC, 32'h0, 4'b0000, 1'b0, 1'b0, 32'hCAFEF00D);
    do_access("bypass_fetch", 32'h10, 32'h0, 4'b0000, 1'b1, 1'b0, 32'hDEADBEEF);
    mpu_en = 1'b1;
  endtask

  task automatic test_overlap();
    cfg_write(2'd0, 32'h100, 32'h1FF, 3'b001, 1'b0);
    cfg_write(2'd1, 32'h000, 32'hFFF, 3'b011, 1'b0);
    do_access("overlap_low_wins", 32'h150, 32'hAAAAAAAA, 4'b1111, 1'b0, 1'b1, 32'h0);
    do_access("overlap_outside", 32'h250, 32'h0BADF00D, 4'b1111, 1'b0, 1'b0, 32'h0);
    do_access("overlap_rd_kept", 32'h150, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
    do_access("overlap_rd_new", 32'h250, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0BADF00D);
    cfg_write(2'd0, 32'h800, 32'h700, 3'b100, 1'b0);
    do_access("inverted_no_hit", 32'h780, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    e.rdata = 32'h0BADF00D;
    e.fault = 1'b0;
    e.ftype = 2'd0;
    e.wen   = 4'b0;
    e.maddr = 22'h94;
    e.inst  = 1'b0;
    e.lat   = 3;
    sb_q.push_back(e);
    e.lat   = 7;
    sb_q.push_back(e);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h250;
    mem_wstrb = 4'b0000;
    mem_instr = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 8) mem_valid = 1'b0;
      if (mem_ready === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected mem_ready at cycle %0d", n);
        end else begin
          got = sb_q.pop_front();
          checks++;
          if (n !== got.lat) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want %0d", n, got.lat);
          end
          checks++;
          if (mem_rdata !== got.rdata) begin
            errors++;
            $display("FAIL b2b_rdata: got %h want %h", mem_rdata, got.rdata);
          end
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_lock();
    cfg_write(2'd1, 32'h0, 32'hFFF, 3'b111, 1'b1);
    cfg_write(2'd1, 32'h0, 32'hFFF, 3'b001, 1'b0);
    do_access("lock_fetch", 32'h40, 32'h0, 4'b0000, 1'b1, 1'b0, 32'h0);
    do_access("lock_write", 32'h40, 32'h12345678, 4'b1111, 1'b0, 1'b0, 32'h0);
    do_access("lock_read", 32'h40, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h12345678);
    do_reset();
    checks++;
    if (fault_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_count: got %h want 0", fault_count);
    end
    do_access("perm_cleared", 32'h40, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
    cfg_write(2'd1, 32'h0, 32'hFFF, 3'b011, 1'b0);
    do_access("unlocked_read", 32'h40, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h12345678);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h300;
    mem_wdata = 32'h55AA55AA;
    mem_wstrb = 4'b1111;
    mem_instr = 1'b0;
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_wen !== 4'b1111) begin
      errors++;
      $display("FAIL mid_access_wen: got %b want 1111", m_wen);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_wen !== 4'b0000) begin
      errors++;
      $display("FAIL async_wen_drop: got %b want 0000", m_wen);
    end
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_ready: got %b want 0", mem_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    cfg_write(2'd1, 32'h0, 32'hFFF, 3'b011, 1'b0);
    do_access("no_partial_write", 32'h300, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.fault_count_q = 16'hFFFD;
    #1;
    release dut.fault_count_q;
    exp_count = 16'hFFFD;
    do_access("sat_fffe", 32'h1000, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
    do_access("sat_ffff", 32'h1004, 32'h0, 4'b0001, 1'b0, 1'b1, 32'h0);
    do_access("sat_hold", 32'h1008, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exec_fault();
    test_range();
    test_overlap();
    test_back_to_back();
    test_lock();
    test_reset_mid_access();
    test_saturate();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
